lot_sensor_debounce: RTL
========================

// Module: lot_sensor_debounce
// PURPOSE
//  Two-channel debounce and edge-extraction stage for the parking-lot gate sensors A and B.
//  Sits between the per-sensor two-flop synchronisers (series_dffs) and the lot entry/exit FSM (lotFSM).
//  Rejects pulses shorter than STABLE_CYCLES and emits clean levels plus 1-cycle rise/fall strobes.
//  The FSM and the car counter therefore only ever see stable sensor transitions.
// PARAMETERS
//  STABLE_CYCLES  500_000      consecutive equal samples needed to accept a level change (10 ms @ 50 MHz); must be >= 1
//  STUCK_CYCLES   500_000_000  cycles a clean level may stay high before it is flagged stuck (10 s @ 50 MHz)
//  CNT_W          $clog2(STABLE_CYCLES+1)  debounce counter width (derived; do not override)
// PORTS
//  clk      in   1  system clock (CLOCK_50 at top level)
//  reset    in   1  synchronous, active-high reset
//  raw_a    in   1  synchronised sensor A (outer beam)
//  raw_b    in   1  synchronised sensor B (inner beam)
//  a        out  1  debounced level of A
//  b        out  1  debounced level of B
//  a_rise   out  1  1-cycle strobe: a went 0->1
//  a_fall   out  1  1-cycle strobe: a went 1->0
//  b_rise   out  1  1-cycle strobe: b went 0->1
//  b_fall   out  1  1-cycle strobe: b went 1->0
//  stuck_a  out  1  A held high >= STUCK_CYCLES (see CONFIGURATION)
//  stuck_b  out  1  B held high >= STUCK_CYCLES (see CONFIGURATION)
// BEHAVIOUR
//  - The two channels are identical and fully independent. Each channel has its own FSM, counter and outputs.
//  - Reset state: every output is 0, both FSMs are in LO, all counters are 0. Reset overrides all other inputs.
//  - Reset mid-check aborts the check. The raw sample taken during the reset cycle is not counted.
//  - FSM states per channel: LO, CHK_HI, HI, CHK_LO. All outputs are registered.
//  - LO: raw=1 -> CHK_HI, cnt=1. raw=0 -> stay in LO.
//  - CHK_HI: raw=0 -> LO, cnt=0.
//  - CHK_HI: raw=1 and cnt==STABLE_CYCLES-1 -> HI, level=1, rise=1 for one cycle.
//  - CHK_HI: raw=1 otherwise -> cnt+1.
//  - HI and CHK_LO mirror LO and CHK_HI with the polarity inverted; acceptance drives level=0 and fall=1.
//  - Latency: the level changes on the same edge that takes the STABLE_CYCLES-th consecutive new-value sample.
//  - With STABLE_CYCLES=1 the level is raw delayed by one cycle.
//  - A bounce back to the old value during CHK_* restarts the count. No strobe fires and the level is unchanged.
//  - Rise and fall strobes are never high in the same cycle on one channel.
//  - Both channels may strobe in the same cycle. Ordering between the channels is preserved with equal latency.
//  - The counter never exceeds STABLE_CYCLES-1 and cannot wrap.
// CONFIGURATION
//  LOT_STUCK_DETECT_EN defined:
//  - Each channel has a saturating counter, cleared whenever its level is 0.
//  - The counter increments every cycle the level is 1.
//  - stuck_x asserts on the edge where the counter reaches STUCK_CYCLES.
//  - stuck_x stays high until the level falls or reset is applied.
//  - stuck_x does not suppress the level or the strobes.
//  LOT_STUCK_DETECT_EN undefined:
//  - No stuck counters are built.
//  - stuck_a and stuck_b are tied to 0. The ports remain so the top level is unchanged.
// TESTING (bench uses STABLE_CYCLES=4, STUCK_CYCLES=10)
//  1 Reset, then raw_a=1 held -> a=1 and a_rise=1 on the 4th post-reset edge; a_rise is 0 on the next cycle.
//  2 raw_a high 3 cycles then low -> a, a_rise and a_fall stay 0 throughout.
//  3 With a=1: raw_a low 2, high 1, low 4 -> a_fall fires once, 4 edges after the final fall; a is 1 until then.
//  4 Car entry sequence A up, B up, A down, B down, 6 cycles apart -> strobes occur in the same order, each 4 cycles after its raw edge.
//  5 raw_a high 2 cycles, reset 1 cycle, raw_a stays high -> a rises 4 edges after reset deasserts, not earlier.
//  6 Macro on: a held high -> stuck_a=1 10 cycles after a_rise; it clears 4 cycles after raw_a falls. Macro off: stuck_a is 0 throughout.
//  All runs: the bench asserts no same-cycle rise+fall on either channel, and a/b match a reference debounce model every cycle.

Source files
------------

// File: rtl/lot_sensor_debounce.sv
// Two-channel debounce and edge extraction for the lot gate sensors A and B.
// Optional stuck-high detection is built only when LOT_STUCK_DETECT_EN is defined.

module lot_debounce_channel #(
    parameter int STABLE_CYCLES = 500_000,
    parameter int STUCK_CYCLES  = 500_000_000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic stuck
);

    typedef enum logic [1:0] {
        LO,
        CHK_HI,
        HI,
        CHK_LO
    } state_t;

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(STABLE_CYCLES - 1);
    localparam bit               ONE_SHOT = (STABLE_CYCLES == 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             going_hi;
    logic             going_lo;

    // With a single-sample window a change is accepted straight from the settled state.
    assign going_hi = raw  && ((state == CHK_HI && cnt == LAST) || (ONE_SHOT && state == LO));
    assign going_lo = !raw && ((state == CHK_LO && cnt == LAST) || (ONE_SHOT && state == HI));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                LO: begin
                    if (going_hi) begin
                        state <= HI;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else if (raw) begin
                        state <= CHK_HI;
                        cnt   <= CNT_W'(1);
                    end
                end
                CHK_HI: begin
                    if (!raw) begin
                        state <= LO;
                        cnt   <= '0;
                    end else if (going_hi) begin
                        state <= HI;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HI: begin
                    if (going_lo) begin
                        state <= LO;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else if (!raw) begin
                        state <= CHK_LO;
                        cnt   <= CNT_W'(1);
                    end
                end
                CHK_LO: begin
                    if (raw) begin
                        state <= HI;
                        cnt   <= '0;
                    end else if (going_lo) begin
                        state <= LO;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= LO;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOT_STUCK_DETECT_EN
    localparam int            SW        = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);

    logic [SW-1:0] stuck_cnt;

    // Cleared on the same edge the level falls, so stuck drops together with the fall strobe.
    always_ff @(posedge clk) begin
        if (reset || !level || going_lo) begin
            stuck_cnt <= '0;
            stuck     <= 1'b0;
        end else if (stuck_cnt != STUCK_MAX) begin
            stuck_cnt <= stuck_cnt + SW'(1);
            stuck     <= (stuck_cnt + SW'(1) == STUCK_MAX);
        end
    end
`else
    assign stuck = 1'b0;
`endif

endmodule

module lot_sensor_debounce #(
    parameter int STABLE_CYCLES = 500_000,
    parameter int STUCK_CYCLES  = 500_000_000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic stuck_a,
    output logic stuck_b
);

    lot_debounce_channel #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_chan_a (
        .clk  (clk),
        .reset(reset),
        .raw  (raw_a),
        .level(a),
        .rise (a_rise),
        .fall (a_fall),
        .stuck(stuck_a)
    );

    lot_debounce_channel #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_chan_b (
        .clk  (clk),
        .reset(reset),
        .raw  (raw_b),
        .level(b),
        .rise (b_rise),
        .fall (b_fall),
        .stuck(stuck_b)
    );

endmodule
